// File: rtl/ultimate_controller_pkg.sv
// Shared game definitions: character IDs, sprite size, screen limits, ult states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ultimate_controller_pkg;

  // Character IDs; also the bit index of each character in alive / collision vectors.
  localparam logic [1:0] CHAR_MAGE     = 2'd0;
  localparam logic [1:0] CHAR_GUNMAN   = 2'd1;
  localparam logic [1:0] CHAR_SWORDMAN = 2'd2;
  localparam logic [1:0] CHAR_FISTMAN  = 2'd3;
  localparam int         NUM_CHARS     = 4;

  localparam int CHARACTER_WIDTH  = 20;
  localparam int CHARACTER_HEIGHT = 20;
  localparam int XLIMIT           = 319;
  localparam int YLIMIT           = 239;

  typedef enum logic [1:0] {
    CHARGING = 2'd0,
    READY    = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } ult_state_t;

  // Latched area-of-effect rectangle, 11-bit so the +extent sums never wrap.
  typedef struct packed {
    logic [10:0] left;
    logic [10:0] right;
    logic [10:0] top;
    logic [10:0] bottom;
  } aoe_box_t;

  // Lower edge of the AOE: p - r, floored at 0 instead of wrapping.
  function automatic logic [10:0] low_bound(input logic [9:0] p, input int r);
    logic [10:0] pe;
    pe = {1'b0, p};
    return (pe >= 11'(r)) ? (pe - 11'(r)) : 11'd0;
  endfunction

  // Upper edge of the AOE: p + sprite extent + r, capped at the screen limit.
  function automatic logic [10:0] high_bound(input logic [9:0] p, input int ext,
                                             input int r, input int lim);
    logic [10:0] s;
    s = {1'b0, p} + 11'(ext) + 11'(r);
    return (s > 11'(lim)) ? 11'(lim) : s;
  endfunction

endpackage

// File: rtl/ultimate_controller_if.sv
// Bundle of the ultimate stage's game-side inputs and health-manager outputs.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level/edge qualified, no handshake.
// master: game/bench side driving buttons, hits, caster, alive mask, positions.
// slave:  ultimate_controller side producing ult_collisions, ultactive, ultready, charge.
interface ultimate_controller_if;
  import ultimate_controller_pkg::*;

  logic                 btnU_ult;
  logic                 hit_in;
  logic [1:0]           currentcharacter;
  logic [NUM_CHARS-1:0] alive;
  logic [9:0]           xmage, ymage, xgunman, ygunman;
  logic [9:0]           xswordman, yswordman, xfistman, yfistman;
  logic [NUM_CHARS-1:0] ult_collisions;
  logic                 ultactive;
  logic                 ultready;
  logic [3:0]           charge;

  modport master (
    output btnU_ult, hit_in, currentcharacter, alive,
    output xmage, ymage, xgunman, ygunman, xswordman, yswordman, xfistman, yfistman,
    input  ult_collisions, ultactive, ultready, charge
  );

  modport slave (
    input  btnU_ult, hit_in, currentcharacter, alive,
    input  xmage, ymage, xgunman, ygunman, xswordman, yswordman, xfistman, yfistman,
    output ult_collisions, ultactive, ultready, charge
  );

endinterface

// File: rtl/ultimate_controller_aoe_box_hit.sv
// Box-vs-character overlap test against an already clamped AOE rectangle.
// Latency: combinational.
// Backpressure: none.
// Ports: en (victim eligible), box (clamped AOE), xi/yi (victim top-left), hit.
module aoe_box_hit
  import ultimate_controller_pkg::*;
(
  input  logic       en,
  input  aoe_box_t   box,
  input  logic [9:0] xi,
  input  logic [9:0] yi,
  output logic       hit
);

  logic [10:0] xe;
  logic [10:0] ye;
  logic [10:0] xr;
  logic [10:0] yb;

  assign xe = {1'b0, xi};
  assign ye = {1'b0, yi};
  assign xr = xe + 11'(CHARACTER_WIDTH);
  assign yb = ye + 11'(CHARACTER_HEIGHT);

  // Strict inequalities: touching edges do not count as overlap.
  assign hit = en && (xe < box.right) && (xr > box.left) &&
               (ye < box.bottom) && (yb > box.top);

endmodule

// File: rtl/ultimate_controller.sv
// Per-character ultimate: charge meter, button-fired AOE, sticky victim vector.
// Latency: fire edge in cycle N -> ultactive at N+1, first victim bit at N+2.
// Backpressure: none; btn/hit edges outside their accepting state are dropped.
// Ports: debouncingclock, reset (sync, active low), ult (slave modport: inputs
//        btnU_ult, hit_in, currentcharacter, alive, positions; outputs
//        ult_collisions, ultactive, ultready, charge).
module ultimate_controller
  import ultimate_controller_pkg::*;
#(
  parameter int CHARGE_MAX     = 8,
  parameter int CHARGE_PERIOD  = 200,
  parameter int ULT_RADIUS     = 30,
  parameter int ACTIVE_TICKS   = 50,
  parameter int COOLDOWN_TICKS = 100
) (
  input logic                 debouncingclock,
  input logic                 reset,
  ultimate_controller_if.slave ult
);

  // One timer is shared by all states; it only needs to hold the largest count.
  localparam int         TW   = $clog2(CHARGE_PERIOD + ACTIVE_TICKS + COOLDOWN_TICKS + 1);
  localparam logic [4:0] CMAX = 5'(CHARGE_MAX);

  ult_state_t           state, state_nxt;
  logic [3:0]           charge_q, charge_nxt;
  logic [4:0]           charge_sum;
  logic [TW-1:0]        tmr_q, tmr_nxt;
  aoe_box_t             box_q, box_nxt;
  logic [NUM_CHARS-1:0] coll_q, coll_nxt;
  logic [NUM_CHARS-1:0] hits;
  logic                 btn_q, hit_q;
  logic                 btn_edge, hit_edge, wrap, caster_alive;
  logic [9:0]           xpos [NUM_CHARS];
  logic [9:0]           ypos [NUM_CHARS];
  logic [9:0]           xc, yc;

  assign xpos[CHAR_MAGE]     = ult.xmage;
  assign ypos[CHAR_MAGE]     = ult.ymage;
  assign xpos[CHAR_GUNMAN]   = ult.xgunman;
  assign ypos[CHAR_GUNMAN]   = ult.ygunman;
  assign xpos[CHAR_SWORDMAN] = ult.xswordman;
  assign ypos[CHAR_SWORDMAN] = ult.yswordman;
  assign xpos[CHAR_FISTMAN]  = ult.xfistman;
  assign ypos[CHAR_FISTMAN]  = ult.yfistman;

  assign xc           = xpos[ult.currentcharacter];
  assign yc           = ypos[ult.currentcharacter];
  assign caster_alive = ult.alive[ult.currentcharacter];

  assign btn_edge   = ult.btnU_ult & ~btn_q;
  assign hit_edge   = ult.hit_in & ~hit_q;
  assign wrap       = (tmr_q == TW'(CHARGE_PERIOD - 1));
  // Passive wrap and hit edge in the same cycle add two.
  assign charge_sum = {1'b0, charge_q} + {4'b0, wrap} + {4'b0, hit_edge};

  for (genvar i = 0; i < NUM_CHARS; i++) begin : g_hit
    aoe_box_hit u_hit (
      .en  (ult.alive[i] && (ult.currentcharacter != 2'(i))),
      .box (box_q),
      .xi  (xpos[i]),
      .yi  (ypos[i]),
      .hit (hits[i])
    );
  end

  always_ff @(posedge debouncingclock) begin
    if (!reset) begin
      state    <= CHARGING;
      charge_q <= '0;
      tmr_q    <= '0;
      box_q    <= '0;
      coll_q   <= '0;
      // Load current inputs so a button/hit held through reset is not an edge.
      btn_q    <= ult.btnU_ult;
      hit_q    <= ult.hit_in;
    end else begin
      state    <= state_nxt;
      charge_q <= charge_nxt;
      tmr_q    <= tmr_nxt;
      box_q    <= box_nxt;
      coll_q   <= coll_nxt;
      btn_q    <= ult.btnU_ult;
      hit_q    <= ult.hit_in;
    end
  end

  always_comb begin
    state_nxt  = state;
    charge_nxt = charge_q;
    tmr_nxt    = tmr_q;
    box_nxt    = box_q;
    coll_nxt   = '0;  // victims only survive while staying in ACTIVE
    unique case (state)
      CHARGING: begin
        tmr_nxt = wrap ? '0 : tmr_q + 1'b1;
        if (charge_sum >= CMAX) begin
          charge_nxt = CMAX[3:0];
          state_nxt  = READY;
          tmr_nxt    = '0;
        end else begin
          charge_nxt = charge_sum[3:0];
        end
      end
      READY: begin
        if (btn_edge && caster_alive) begin
          state_nxt  = ACTIVE;
          charge_nxt = '0;
          tmr_nxt    = '0;
          // Box is frozen at fire time; later caster movement does not drag it.
          box_nxt = '{left:   low_bound(xc, ULT_RADIUS),
                      right:  high_bound(xc, CHARACTER_WIDTH, ULT_RADIUS, XLIMIT),
                      top:    low_bound(yc, ULT_RADIUS),
                      bottom: high_bound(yc, CHARACTER_HEIGHT, ULT_RADIUS, YLIMIT)};
        end
      end
      ACTIVE: begin
        if (!caster_alive || (tmr_q == TW'(ACTIVE_TICKS - 1))) begin
          state_nxt = COOLDOWN;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt  = tmr_q + 1'b1;
          coll_nxt = coll_q | hits;  // sticky: one hit per victim per activation
        end
      end
      COOLDOWN: begin
        if (tmr_q == TW'(COOLDOWN_TICKS - 1)) begin
          state_nxt = CHARGING;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr_q + 1'b1;
        end
      end
      default: state_nxt = CHARGING;
    endcase
  end

  assign ult.ult_collisions = coll_q;
  assign ult.ultactive      = (state == ACTIVE);
  assign ult.ultready       = (state == READY);
  assign ult.charge         = charge_q;

endmodule

// File: doc/ultimate_controller.md
Name: ultimate_controller

Overview:
- Per-character ultimate-ability stage. Sits beside the projectile stage and directly upstream of the health manager; one instance per character.
- Builds up a charge meter over time and from projectile hits.
- On a button edge, fires a fixed-duration area-of-effect box centred on the caster.
- Drives a 4-bit victim vector into that character's nibble of the health manager's ult_collisions bus.

Parameters:
- CHARGE_MAX, 8: charge level at which the ultimate becomes ready; 4-bit meter.
- CHARGE_PERIOD, 200: debouncingclock ticks per passive +1 charge.
- ULT_RADIUS, 30: pixels the AOE extends beyond the caster box on each side.
- ACTIVE_TICKS, 50: ticks the AOE stays live.
- COOLDOWN_TICKS, 100: ticks after ACTIVE before charging resumes.

Ports:
- debouncingclock  in  1  sole clock.
- reset  in  1  synchronous, active-low; 0 resets.
- btnU_ult  in  1  fire request; rising edge detected internally.
- hit_in  in  1  this character's projectile hit indication (OR of its collision vector); rising edge adds charge.
- currentcharacter  in  2  caster ID (00 mage, 01 gunman, 10 swordman, 11 fistman).
- alive  in  4  per-character alive mask, same bit order.
- xmage, ymage, xgunman, ygunman, xswordman, yswordman, xfistman, yfistman  in  10 each  character top-left positions.
- ult_collisions  out  4  victim bits: bit0 mage, bit1 gunman, bit2 swordman, bit3 fistman.
- ultactive  out  1  high while in ACTIVE.
- ultready  out  1  high while in READY.
- charge  out  4  current meter value.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=CHARGING; charge=0; all counters=0; ult_collisions=0; ultactive=0; ultready=0.
  - Edge-detect registers are loaded with the current inputs, so there is no spurious edge on release.
  - Reset has priority over everything, including mid-ACTIVE and mid-COOLDOWN.
- Caster position is selected from the eight position inputs by currentcharacter.
- CHARGING:
  - Passive tick counter counts 0..CHARGE_PERIOD-1.
  - On wrap, charge+1.
  - On a hit_in rising edge, charge+1.
  - If both occur in the same cycle, charge+2.
  - charge saturates at CHARGE_MAX.
  - When the next-cycle charge equals CHARGE_MAX, go to READY.
  - btn edges are ignored in CHARGING.
- READY:
  - ultready=1.
  - A btn edge with alive[currentcharacter]==1 goes to ACTIVE.
  - A btn edge with the caster dead is ignored.
  - Sampling rule: the edge must be sampled while the state is already READY; an edge in the same cycle charge reaches max does not fire.
- Entry to ACTIVE (cycle N+1 after an edge in cycle N):
  - AOE box is latched from the caster position at that moment; it does not follow later movement.
  - Box bounds use 11-bit arithmetic:
    - left = max(0, xc-ULT_RADIUS)
    - right = min(319, xc+20+ULT_RADIUS)
    - top = max(0, yc-ULT_RADIUS)
    - bottom = min(239, yc+20+ULT_RADIUS)
  - No wrap-around at any boundary.
  - charge=0; active counter=0; ultactive=1.
- ACTIVE, per cycle:
  - For each character i, hit_i = alive[i] && i!=currentcharacter && (xi<right) && (xi+20>left) && (yi<bottom) && (yi+20>top).
  - All inequalities are strict; xi+20 is computed in 11 bits.
  - ult_collisions is registered and sticky: bit |= hit_i. The first bit can rise at cycle N+2.
  - Once a bit is set it is held until ACTIVE ends, so the health manager counts exactly one hit per victim per activation.
  - After ACTIVE_TICKS cycles in ACTIVE, go to COOLDOWN.
  - If the caster's alive bit drops, abort immediately to COOLDOWN.
- COOLDOWN:
  - ult_collisions=0 and ultactive=0 from the first COOLDOWN cycle.
  - hit_in and btn are ignored; charge holds at 0.
  - After COOLDOWN_TICKS cycles, go to CHARGING; the passive counter restarts from 0.
- Invariants:
  - ult_collisions is 0 whenever state≠ACTIVE.
  - ultactive and ultready are never both 1.

Decomposition:
- Shared game package:
  - character ID constants;
  - CHARACTER_WIDTH/HEIGHT=20;
  - XLIMIT=319, YLIMIT=239;
  - collision-vector bit order;
  - the ult state enum (CHARGING, READY, ACTIVE, COOLDOWN).
- One natural sub-module, aoe_box_hit: a combinational box-vs-character overlap test with clamped bounds, instantiated four times.
- Edge detectors stay inline.

Test Plan (CHARGE_MAX=4, CHARGE_PERIOD=4, ACTIVE_TICKS=5, COOLDOWN_TICKS=6, ULT_RADIUS=30):
- Charge and ready: hold reset=0 for 2 cycles, then release with no stimulus → all outputs 0; charge steps 1,2,3,4 every 4 cycles; ultready=1 at charge 4. A btn edge during charge 2 does nothing.
- Fire and victim selection: caster mage at (100,100); gunman (140,100); swordman (200,100); fistman (60,60); all alive; btn edge in READY:
  - ultactive high for 5 cycles;
  - ult_collisions=4'b1010 from the second cycle after the edge, held through ACTIVE;
  - 0 in COOLDOWN; charge=0.
- Clamp with no wrap: caster at (5,5), victim gunman at (0,0) → bit1 set. Victim swordman at (300,219) → bit2 never set.
- Masks and abort: fistman dead and overlapping → bit3 stays 0. Drop alive[0] mid-ACTIVE → COOLDOWN next cycle, ult_collisions=0.
- Hit charging: CHARGE_PERIOD large, 3 hit_in pulses → charge=3. A pulse coincident with a passive wrap → +2. hit_in pulses during COOLDOWN → charge stays 0.
- Reset mid-ACTIVE: reset=0 on the 3rd ACTIVE cycle → next edge: state CHARGING, all outputs 0; with btn held high through release, no fire afterwards.
